lsu_ctrl: RTL and testbench

Load/store initiator sitting between the RV32I execute stage and `data_mem`. It accepts one load/store request at a time from the core and computes the effective address. It checks legality, alignment and range, then drives the data-memory strobes for one cycle. It returns either the load data or a fault cause through a valid/ready response handshake.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_ctrl_if.sv | 48 ++++
 rtl/lsu_access_check.sv | 57 +++++
 rtl/lsu_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, access sizes,
// fault causes and controller state encoding.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_ACCESS     = 2'b10,
    CAUSE_ILLEGAL    = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  // Reserved size only occurs with an illegal funct3, so its byte count is moot.
  function automatic logic [2:0] size_bytes(mem_size_e size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response handshake plus data-memory strobes of the load/store
// initiator; the controller is the slave, the core/memory environment the master.
interface lsu_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic [1:0]  resp_cause;
  logic [31:0] resp_addr;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_is_signed;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_fault, resp_cause, resp_addr,
    output resp_ready,
    input  mem_addr, mem_wdata, mem_read, mem_write, mem_size, mem_is_signed,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_fault, resp_cause, resp_addr,
    input  resp_ready,
    output mem_addr, mem_wdata, mem_read, mem_write, mem_size, mem_is_signed,
    input  mem_rdata
  );

endinterface

// File: rtl/lsu_access_check.sv
// Combinational decode of a load/store: access size, signedness and the
// prioritised fault cause (illegal > misaligned > out of range).
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE_BYTES = 1024
) (
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] addr,
  output mem_size_e   size,
  output logic        is_signed,
  output logic        fault,
  output cause_e      cause
);

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] end_addr;

  assign size      = mem_size_e'(funct3[1:0]);
  assign is_signed = !funct3[2];

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    illegal = 1'b1;
    if (is_store) begin
      case (funct3)
        F3_SB, F3_SH, F3_SW: illegal = 1'b0;
        default:             illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal = 1'b0;
        default:                             illegal = 1'b1;
      endcase
    end
  end

  assign misaligned = ((size == SIZE_HALF) && addr[0]) ||
                      ((size == SIZE_WORD) && (addr[1:0] != 2'b00));

  // One extra bit so an access running past 2^32 still registers as out of range.
  assign end_addr     = {1'b0, addr} + 33'(size_bytes(size));
  assign out_of_range = end_addr > 33'(MEMORY_SIZE_BYTES);

  always_comb begin
    cause = CAUSE_NONE;
    if (illegal)           cause = CAUSE_ILLEGAL;
    else if (misaligned)   cause = CAUSE_MISALIGNED;
    else if (out_of_range) cause = CAUSE_ACCESS;
  end

  assign fault = (cause != CAUSE_NONE);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: accepts one core request, checks it, strobes data_mem
// for one cycle and returns load data or a fault through a valid/ready response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE_BYTES = 1024
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        accept;
  logic [31:0] eff_addr;

  mem_size_e   chk_size;
  logic        chk_signed;
  logic        chk_fault;
  cause_e      chk_cause;

  logic        is_store_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;
  logic        fault_q;
  cause_e      cause_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  mem_size_e   mem_size_q;
  logic        mem_signed_q;

  assign eff_addr = bus.req_base + bus.req_offset;
  assign accept   = bus.req_valid && bus.req_ready;

  lsu_access_check #(
    .MEMORY_SIZE_BYTES (MEMORY_SIZE_BYTES)
  ) u_check (
    .funct3    (bus.req_funct3),
    .is_store  (bus.req_is_store),
    .addr      (eff_addr),
    .size      (chk_size),
    .is_signed (chk_signed),
    .fault     (chk_fault),
    .cause     (chk_cause)
  );

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Strobes decode straight from the state so an async reset drops them at once.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = chk_fault ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        bus.mem_read  = !is_store_q;
        bus.mem_write = is_store_q;
        state_d       = is_store_q ? S_RESP : S_WAIT;
      end
      S_WAIT: state_d = S_RESP;
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q   <= 1'b0;
      addr_q       <= '0;
      rd_q         <= '0;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= SIZE_BYTE;
      mem_signed_q <= 1'b0;
    end else begin
      if (accept) begin
        is_store_q <= bus.req_is_store;
        addr_q     <= eff_addr;
        rd_q       <= bus.req_rd;
        fault_q    <= chk_fault;
        cause_q    <= chk_cause;
        rdata_q    <= '0;
        // Memory-side outputs only move for accesses that will actually issue.
        if (!chk_fault) begin
          mem_addr_q   <= eff_addr;
          mem_wdata_q  <= bus.req_wdata;
          mem_size_q   <= chk_size;
          mem_signed_q <= chk_signed;
        end
      end
      if (state_q == S_WAIT) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_rd       = rd_q;
  assign bus.resp_fault    = fault_q;
  assign bus.resp_cause    = cause_q;
  assign bus.resp_addr     = addr_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_size      = mem_size_q;
  assign bus.mem_is_signed = mem_signed_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl against a small byte-addressed data_mem model
// with a registered, size/sign-aware read port.
module tb_lsu_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lsu_ctrl_if bus ();

  lsu_ctrl #(
    .MEMORY_SIZE_BYTES (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [1024];

  always @(posedge clk) begin
    logic [9:0] a;
    logic [7:0] b0, b1, b2, b3;
    a  = bus.mem_addr[9:0];
    b0 = mem[a];
    b1 = mem[a + 10'd1];
    b2 = mem[a + 10'd2];
    b3 = mem[a + 10'd3];
    if (bus.mem_write) begin
      mem[a] <= bus.mem_wdata[7:0];
      if (bus.mem_size != 2'b00) mem[a + 10'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_size == 2'b10) begin
        mem[a + 10'd2] <= bus.mem_wdata[23:16];
        mem[a + 10'd3] <= bus.mem_wdata[31:24];
      end
    end
    if (bus.mem_read) begin
      case (bus.mem_size)
        2'b00:   bus.mem_rdata <= bus.mem_is_signed ? {{24{b0[7]}}, b0} : {24'h0, b0};
        2'b01:   bus.mem_rdata <= bus.mem_is_signed ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
        default: bus.mem_rdata <= {b3, b2, b1, b0};
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input int exp_lat, input logic [1:0] exp_cause,
                         input logic [31:0] exp_rdata, input logic [31:0] exp_addr,
                         input logic [1:0] exp_size, input logic exp_signed,
                         input int stall);
    int          lat;
    int          nstb;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_size;
    logic        s_signed;
    logic        s_wr;
    s_addr = '0; s_wdata = '0; s_size = '0; s_signed = 1'b0; s_wr = 1'b0;

    check({tag, "_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_base     = base;
    bus.req_offset   = off;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_valid    = 1'b0;

    lat  = 1;
    nstb = 0;
    while (!bus.resp_valid && lat < 8) begin
      check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
      if (bus.mem_read || bus.mem_write) begin
        nstb++;
        s_addr   = bus.mem_addr;
        s_wdata  = bus.mem_wdata;
        s_size   = bus.mem_size;
        s_signed = bus.mem_is_signed;
        s_wr     = bus.mem_write;
      end
      tick();
      lat++;
    end

    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_strobes"}, 32'(nstb), (exp_cause == 2'b00) ? 32'd1 : 32'd0);
    if (exp_cause == 2'b00) begin
      check({tag, "_mem_addr"}, s_addr, exp_addr);
      check({tag, "_mem_size"}, 32'(s_size), 32'(exp_size));
      check({tag, "_mem_signed"}, 32'(s_signed), 32'(exp_signed));
      check({tag, "_mem_write"}, 32'(s_wr), 32'(st));
      if (st) check({tag, "_mem_wdata"}, s_wdata, wdata);
    end
    check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    check({tag, "_fault"}, 32'(bus.resp_fault), (exp_cause != 2'b00) ? 32'd1 : 32'd0);
    check({tag, "_cause"}, 32'(bus.resp_cause), 32'(exp_cause));
    check({tag, "_addr"}, bus.resp_addr, exp_addr);
    check({tag, "_rd"}, 32'(bus.resp_rd), 32'(rd));

    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, "_stall_rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, "_stall_ready"}, 32'(bus.req_ready), 32'd0);
      check({tag, "_stall_strobe"}, 32'(bus.mem_read || bus.mem_write), 32'd0);
    end

    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_resp_done"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_base     = '0;
    bus.req_offset   = '0;
    bus.req_wdata    = '0;
    bus.req_rd       = '0;
    bus.resp_ready   = 1'b0;
    bus.mem_rdata    = '0;
    rst = 1'b1;
    #2;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_strobes", 32'(bus.mem_read || bus.mem_write), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_size", 32'(bus.mem_size), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_addr", bus.resp_addr, 32'h0);
    check("rst_resp_cause", 32'(bus.resp_cause), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    //       tag            st    f3      base          off    wdata          rd  lat cause  rdata          addr          size  sgn stall
    run_req("sw",          1'b1, 3'b010, 32'h100,      32'h4, 32'hDEADBEEF,  0,  2, 2'b00, 32'h0,         32'h104,      2'b10, 1, 0);
    run_req("sb",          1'b1, 3'b000, 32'h104,      32'h0, 32'h00000080,  1,  2, 2'b00, 32'h0,         32'h104,      2'b00, 1, 0);
    run_req("lb",          1'b0, 3'b000, 32'h100,      32'h4, 32'h0,         5,  3, 2'b00, 32'hFFFFFF80,  32'h104,      2'b00, 1, 0);
    run_req("lbu",         1'b0, 3'b100, 32'h104,      32'h0, 32'h0,         6,  3, 2'b00, 32'h00000080,  32'h104,      2'b00, 0, 0);
    run_req("lw_stall",    1'b0, 3'b010, 32'h104,      32'h0, 32'h0,         7,  3, 2'b00, 32'hDEADBE80,  32'h104,      2'b10, 1, 5);
    run_req("lh",          1'b0, 3'b001, 32'h104,      32'h0, 32'h0,         8,  3, 2'b00, 32'hFFFFBE80,  32'h104,      2'b01, 1, 0);
    run_req("lhu",         1'b0, 3'b101, 32'h106,      32'h0, 32'h0,         9,  3, 2'b00, 32'h0000DEAD,  32'h106,      2'b01, 0, 0);
    run_req("lw_misalign", 1'b0, 3'b010, 32'h100,      32'h2, 32'h0,        10,  1, 2'b01, 32'h0,         32'h102,      2'b00, 0, 0);
    run_req("lh_3ff",      1'b0, 3'b001, 32'h3FF,      32'h0, 32'h0,        11,  1, 2'b01, 32'h0,         32'h3FF,      2'b00, 0, 0);
    run_req("sb_400",      1'b1, 3'b000, 32'h400,      32'h0, 32'h55,       12,  1, 2'b10, 32'h0,         32'h400,      2'b00, 0, 0);
    run_req("sw_3fc",      1'b1, 3'b010, 32'h3FC,      32'h0, 32'hCAFEF00D, 13,  2, 2'b00, 32'h0,         32'h3FC,      2'b10, 1, 0);
    run_req("lw_3fc",      1'b0, 3'b010, 32'h3FC,      32'h0, 32'h0,        14,  3, 2'b00, 32'hCAFEF00D,  32'h3FC,      2'b10, 1, 0);
    run_req("ld_f3_011",   1'b0, 3'b011, 32'h100,      32'h0, 32'h0,        15,  1, 2'b11, 32'h0,         32'h100,      2'b00, 0, 0);
    run_req("st_f3_100",   1'b1, 3'b100, 32'h100,      32'h0, 32'h0,        16,  1, 2'b11, 32'h0,         32'h100,      2'b00, 0, 0);
    run_req("ill_over_mis",1'b0, 3'b111, 32'h101,      32'h0, 32'h0,        17,  1, 2'b11, 32'h0,         32'h101,      2'b00, 0, 0);
    run_req("lw_wrap",     1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0,        18,  3, 2'b00, 32'h0,         32'h4,        2'b10, 1, 0);
    run_req("lw_high",     1'b0, 3'b010, 32'hFFFFFFF0, 32'h0, 32'h0,        19,  1, 2'b10, 32'h0,         32'hFFFFFFF0, 2'b00, 0, 0);

    // Reset lands in the middle of a store's ISSUE cycle.
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_base     = 32'h200;
    bus.req_offset   = 32'h0;
    bus.req_wdata    = 32'h12345678;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_valid    = 1'b0;
    check("rst_issue_write_before", 32'(bus.mem_write), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_issue_write_drop", 32'(bus.mem_write), 32'd0);
    check("rst_issue_read_drop", 32'(bus.mem_read), 32'd0);
    check("rst_issue_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);

    run_req("lw_post_rst", 1'b0, 3'b010, 32'h104,      32'h0, 32'h0,        20,  3, 2'b00, 32'hDEADBE80,  32'h104,      2'b10, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
